// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants: the queue entry layout,
// the instruction width in bytes and the default boot address.
package riscv_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_PC_START_ADDRESS = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundles the instruction-memory port and the pipeline-facing queue port of fetch_queue.
interface fetch_queue_if;

  logic [31:0] instructionAddress;
  logic [31:0] instruction;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  modport master (
    output instructionAddress,
    input  instruction,
    output inst_o,
    output pc_o,
    output valid_o,
    input  ready_i,
    input  redirect_i,
    input  redirect_pc_i
  );

  modport slave (
    input  instructionAddress,
    output instruction,
    input  inst_o,
    input  pc_o,
    input  valid_o,
    output ready_i,
    output redirect_i,
    output redirect_pc_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with push/pop/clear and an occupancy count.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     push_entry,
  output fetch_entry_t     head_entry,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             pop_ok;
  logic             push_ok;

  // Guard against underflow and overflow even if the caller does not.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !clear) mem[tail] <= push_entry;
  end

  // Storage is never reset, so an empty queue presents zeros instead of stale data.
  assign head_entry = (count == '0) ? '0 : mem[head];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, pushes memory words into
// fetch_fifo and hands them to the pipeline; redirects flush and retarget.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter logic [31:0] PC_START_ADDRESS = DEFAULT_PC_START_ADDRESS,
  parameter int unsigned DEPTH = 4
) (
  input logic           clock,
  input logic           reset,
  fetch_queue_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  // Redirect wins over both directions; a full queue only accepts a word when it also drains one.
  assign pop  = bus.valid_o && bus.ready_i && !bus.redirect_i;
  assign push = !bus.redirect_i && ((count != CNT_W'(DEPTH)) || pop);

  assign push_entry.pc    = fetch_pc;
  assign push_entry.instr = bus.instruction;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= PC_START_ADDRESS;
    end else if (bus.redirect_i) begin
      fetch_pc <= {bus.redirect_pc_i[31:2], 2'b00};
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (bus.redirect_i),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .count      (count)
  );

  assign bus.instructionAddress = fetch_pc;
  assign bus.valid_o            = (count != '0);
  assign bus.inst_o             = head_entry.instr;
  assign bus.pc_o               = head_entry.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: boot sequence, backpressure, full-queue
// pop/push, redirect flush, asynchronous reset and fetch PC wraparound.
module tb_fetch_queue;

  logic clock;
  logic reset;
  logic memPattern;
  int   checks;
  int   errors;

  fetch_queue_if bus ();

  fetch_queue #(
    .PC_START_ADDRESS (32'h0040_0000),
    .DEPTH            (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: constant NOP, or an address-tagged word so inst_o can be traced to its pc.
  assign bus.instruction = memPattern ? {bus.instructionAddress[15:0], 16'h0013} : 32'h0000_0013;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic redirect, input logic [31:0] redirectPc);
    bus.ready_i       = ready;
    bus.redirect_i    = redirect;
    bus.redirect_pc_i = redirectPc;
    @(posedge clock);
    #1;
  endtask

  task automatic releaseFromReset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    memPattern        = 1'b0;
    reset             = 1'b0;
    bus.ready_i       = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;

    #12;
    checkOutput("reset_valid", 32'(bus.valid_o), 32'd0);
    checkOutput("reset_addr", bus.instructionAddress, 32'h0040_0000);
    checkOutput("reset_pc_o", bus.pc_o, 32'h0);
    checkOutput("reset_inst_o", bus.inst_o, 32'h0);

    // Boot stream with the pipeline always ready.
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("boot_valid_e1", 32'(bus.valid_o), 32'd1);
    checkOutput("boot_pc_e1", bus.pc_o, 32'h0040_0000);
    checkOutput("boot_inst_e1", bus.inst_o, 32'h0000_0013);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("boot_pc_e2", bus.pc_o, 32'h0040_0004);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("boot_pc_e3", bus.pc_o, 32'h0040_0008);
    checkOutput("boot_addr_e3", bus.instructionAddress, 32'h0040_000C);

    // Backpressure from reset: queue fills to four and the fetch PC stalls.
    bus.ready_i = 1'b0;
    releaseFromReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("stall_valid", 32'(bus.valid_o), 32'd1);
    end
    checkOutput("stall_addr", bus.instructionAddress, 32'h0040_0010);
    checkOutput("stall_pc_o", bus.pc_o, 32'h0040_0000);

    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("full_pop_addr", bus.instructionAddress, 32'h0040_0014);
    checkOutput("full_pop_pc_o", bus.pc_o, 32'h0040_0004);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("still_full_addr", bus.instructionAddress, 32'h0040_0014);
    checkOutput("still_full_pc_o", bus.pc_o, 32'h0040_0004);

    // Redirect on a non-empty queue with the pipeline ready.
    memPattern = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h0040_0042);
    checkOutput("redir_valid", 32'(bus.valid_o), 32'd0);
    checkOutput("redir_addr", bus.instructionAddress, 32'h0040_0040);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redir_tgt_valid", 32'(bus.valid_o), 32'd1);
    checkOutput("redir_tgt_pc_o", bus.pc_o, 32'h0040_0040);
    checkOutput("redir_tgt_inst", bus.inst_o, 32'h0040_0013);
    checkOutput("redir_tgt_addr", bus.instructionAddress, 32'h0040_0044);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir_next_pc_o", bus.pc_o, 32'h0040_0044);
    checkOutput("redir_next_inst", bus.inst_o, 32'h0044_0013);

    // Asynchronous reset mid-operation with three entries and a pending redirect.
    bus.ready_i = 1'b0;
    releaseFromReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("three_addr", bus.instructionAddress, 32'h0040_000C);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h1234_5678;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_valid", 32'(bus.valid_o), 32'd0);
    checkOutput("async_addr", bus.instructionAddress, 32'h0040_0000);
    checkOutput("async_pc_o", bus.pc_o, 32'h0);
    bus.redirect_i = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("rerun_valid", 32'(bus.valid_o), 32'd1);
    checkOutput("rerun_pc_o", bus.pc_o, 32'h0040_0000);
    checkOutput("rerun_addr", bus.instructionAddress, 32'h0040_0004);

    // Fetch PC wraparound at the top of the address space.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
    checkOutput("wrap_redir_valid", 32'(bus.valid_o), 32'd0);
    checkOutput("wrap_redir_addr", bus.instructionAddress, 32'hFFFF_FFF8);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap_pc_0", bus.pc_o, 32'hFFFF_FFF8);
    checkOutput("wrap_inst_0", bus.inst_o, 32'hFFF8_0013);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap_pc_1", bus.pc_o, 32'hFFFF_FFFC);
    checkOutput("wrap_inst_1", bus.inst_o, 32'hFFFC_0013);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap_pc_2", bus.pc_o, 32'h0000_0000);
    checkOutput("wrap_inst_2", bus.inst_o, 32'h0000_0013);
    checkOutput("wrap_addr", bus.instructionAddress, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter PC_START_ADDRESS, default 32'h00400000, first byte address fetched after reset.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 instructionAddress  output  32  byte address presented to instruction memory.
REQ-006 instruction  input  32  instruction-memory word for instructionAddress, valid in the same cycle (combinational read).
REQ-007 inst_o  output  32  instruction at queue head.
REQ-008 pc_o  output  32  byte address of inst_o.
REQ-009 valid_o  output  1  head entry present.
REQ-010 ready_i  input  1  pipeline consumes head when valid_o && ready_i (pop).
REQ-011 redirect_i  input  1  taken branch/jump from pipeline; flushes queue.
REQ-012 redirect_pc_i  output-side target, input  32  new fetch byte address when redirect_i is high.

Function
REQ-013 instructionAddress SHALL equal the internal fetch PC register at all times.
REQ-014 Push: when redirect_i is low and (count < DEPTH or a pop occurs this cycle), the block SHALL write {fetch PC, instruction} at the tail and advance fetch PC by 4.
REQ-015 Full without pop: no push; fetch PC and instructionAddress SHALL hold.
REQ-016 Pop SHALL advance the head pointer; simultaneous push and pop SHALL leave count unchanged.
REQ-017 valid_o SHALL equal (count != 0); inst_o/pc_o SHALL be the head entry, driven from registered storage.
REQ-018 Fetch latency: an instruction pushed on edge N SHALL be visible at inst_o from edge N (valid_o high after that edge) when the queue was empty.
REQ-019 Redirect SHALL take priority over push and pop: on that edge count, head and tail SHALL clear to 0 and fetch PC SHALL load {redirect_pc_i[31:2], 2'b00}; the current instruction input is discarded.
REQ-020 valid_o SHALL be low in the cycle after a redirect; the target instruction SHALL appear at inst_o one edge later.
REQ-021 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH with no overflow or underflow.
REQ-022 Fetch PC SHALL wrap 32'hFFFFFFFC -> 32'h00000000 with no error indication.
REQ-023 Popping when valid_o is low SHALL have no effect.
REQ-024 inst_o and pc_o are don't-care while valid_o is low.

Reset
REQ-025 Asserting reset SHALL immediately set fetch PC = PC_START_ADDRESS, count = 0, head = tail = 0, valid_o = 0, independent of clock.
REQ-026 Reset asserted mid-operation SHALL discard all entries and any pending redirect.
REQ-027 Storage contents need no reset; inst_o and pc_o SHALL read 0 after reset.
REQ-028 First push SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-029 Shared package riscv_pkg SHALL hold fetch_entry_t {pc[31:0], instr[31:0]}, the INSTR_BYTES = 4 constant and the default PC_START_ADDRESS.
REQ-030 Storage and pointers SHALL live in one sub-module, fetch_fifo (DEPTH x fetch_entry_t, push/pop/clear, count output); fetch_queue holds the PC and control.

Verification
REQ-031 Reset release, ready_i = 1, memory returns 32'h00000013 at every address -> pc_o sequence 0x00400000, 0x00400004, 0x00400008 on consecutive cycles, valid_o high from edge 1.
REQ-032 ready_i = 0 for 10 cycles -> count reaches 4; instructionAddress holds 0x00400010; valid_o stays high; pc_o stays 0x00400000.
REQ-033 Full queue, ready_i = 1 for one cycle -> pop and push on the same edge; count stays 4; instructionAddress becomes 0x00400014.
REQ-034 redirect_i = 1, redirect_pc_i = 0x00400042, with ready_i = 1 and queue non-empty -> valid_o low the next cycle; then pc_o = 0x00400040; no stale entry popped.
REQ-035 reset pulled low between clock edges with 3 entries queued -> valid_o = 0 and instructionAddress = 0x00400000 before the next edge.
REQ-036 Redirect to 0xFFFFFFF8, ready_i = 1 -> pc_o sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
